// File: rtl/alarm_sequencer.sv
// rtl/alarm_sequencer.sv - time-of-day alarm controller: alarm storage, match, ring/snooze/stop/timeout sequencing
//
// Optional feature macro: ALARM_DAILY_REARM_EN
//   defined   : the end of an alarm event returns to ARMED (fires again next day);
//               re-match is held off until the running time leaves the alarm time
//   undefined : the end of an alarm event returns to DISARMED (btn_arm needed)
//
// Ports:
//   clk            system clock
//   reset_n        asynchronous active-low reset (assert async, deassert sync)
//   tick           one-cycle pulse per second, same cycle the clock counter advances
//   cur_hours      running hours   (0..23)
//   cur_minutes    running minutes (0..59)
//   cur_seconds    running seconds (0..59)
//   set_en         one-cycle request to load set_hours/set_minutes/set_seconds
//   set_hours      alarm hours to load
//   set_minutes    alarm minutes to load
//   set_seconds    alarm seconds to load
//   btn_arm        pre-debounced pulse: arm the alarm
//   btn_snooze     pre-debounced pulse: snooze a ringing alarm
//   btn_stop       pre-debounced pulse: stop / disarm
//   alarm_hours    stored alarm hours
//   alarm_minutes  stored alarm minutes
//   alarm_seconds  stored alarm seconds
//   state          0=DISARMED 1=ARMED 2=RINGING 3=SNOOZE
//   buzzer         registered, high exactly while state==RINGING
//   snooze_count   snoozes used in the current event (saturates at MAX_SNOOZE)
//   set_err        one-cycle pulse: set request rejected

module alarm_sequencer #(
    parameter int SNOOZE_SECS       = 300,
    parameter int RING_TIMEOUT_SECS = 60,
    parameter int MAX_SNOOZE        = 3
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       tick,
    input  logic [7:0] cur_hours,
    input  logic [7:0] cur_minutes,
    input  logic [7:0] cur_seconds,
    input  logic       set_en,
    input  logic [7:0] set_hours,
    input  logic [7:0] set_minutes,
    input  logic [7:0] set_seconds,
    input  logic       btn_arm,
    input  logic       btn_snooze,
    input  logic       btn_stop,
    output logic [7:0] alarm_hours,
    output logic [7:0] alarm_minutes,
    output logic [7:0] alarm_seconds,
    output logic [1:0] state,
    output logic       buzzer,
    output logic [1:0] snooze_count,
    output logic       set_err
);

    localparam int CNT_MAX = (SNOOZE_SECS > RING_TIMEOUT_SECS) ? SNOOZE_SECS : RING_TIMEOUT_SECS;
    localparam int CW      = $clog2(CNT_MAX + 1);

    localparam logic [CW-1:0] RING_LOAD    = CW'(RING_TIMEOUT_SECS);
    localparam logic [CW-1:0] SNOOZE_LOAD  = CW'(SNOOZE_SECS);
    localparam logic [CW-1:0] CNT_ONE      = CW'(1);
    localparam logic [1:0]    SNOOZE_LIMIT = 2'(MAX_SNOOZE);

    typedef enum logic [1:0] {
        ST_DISARMED = 2'd0,
        ST_ARMED    = 2'd1,
        ST_RINGING  = 2'd2,
        ST_SNOOZE   = 2'd3
    } state_t;

`ifdef ALARM_DAILY_REARM_EN
    localparam state_t END_STATE = ST_ARMED;
`else
    localparam state_t END_STATE = ST_DISARMED;
`endif

    state_t        state_q;
    state_t        state_d;
    logic [CW-1:0] ring_q;
    logic [CW-1:0] ring_d;
    logic [CW-1:0] snz_q;
    logic [CW-1:0] snz_d;
    logic [1:0]    count_q;
    logic [1:0]    count_d;
    logic [7:0]    ahours_q;
    logic [7:0]    aminutes_q;
    logic [7:0]    aseconds_q;
    logic          buzzer_q;
    logic          set_err_q;

    logic          time_match;
    logic          set_valid;
    logic          set_load;
    logic          set_reject;
    logic          press_stop;
    logic          press_snooze;
    logic          press_arm;
    logic          end_event;
    logic          rearm_block;

    // Matching is plain field equality, so midnight rollover needs no special case.
    assign time_match = (cur_hours   == ahours_q)   &&
                        (cur_minutes == aminutes_q) &&
                        (cur_seconds == aseconds_q);

    assign set_valid  = (set_hours <= 8'd23) && (set_minutes <= 8'd59) && (set_seconds <= 8'd59);
    assign set_load   = set_en && (state_q != ST_RINGING) && set_valid;
    assign set_reject = set_en && !set_load;

    // Only the highest-priority button pressed this cycle is considered.
    assign press_stop   = btn_stop;
    assign press_snooze = btn_snooze && !btn_stop;
    assign press_arm    = btn_arm && !btn_snooze && !btn_stop;

`ifdef ALARM_DAILY_REARM_EN
    // After an event ends we are back in ARMED while the match second may still
    // be running; hold off re-matching until the running time moves on.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rearm_block <= 1'b0;
        end else if (end_event) begin
            rearm_block <= 1'b1;
        end else if (!time_match) begin
            rearm_block <= 1'b0;
        end
    end
`else
    assign rearm_block = 1'b0;
`endif

    always_comb begin
        state_d   = state_q;
        ring_d    = ring_q;
        snz_d     = snz_q;
        count_d   = count_q;
        end_event = 1'b0;

        case (state_q)
            ST_DISARMED: begin
                if (press_arm) begin
                    state_d = ST_ARMED;
                end
            end

            ST_ARMED: begin
                if (press_stop) begin
                    state_d = ST_DISARMED;
                end else if (tick && time_match && !rearm_block) begin
                    state_d = ST_RINGING;
                    ring_d  = RING_LOAD;
                    count_d = 2'd0;
                end
            end

            ST_RINGING: begin
                if (press_stop) begin
                    end_event = 1'b1;
                end else if (press_snooze && (count_q < SNOOZE_LIMIT)) begin
                    state_d = ST_SNOOZE;
                    snz_d   = SNOOZE_LOAD;
                    count_d = count_q + 2'd1;
                end else if (tick) begin
                    // A snooze at the limit is ignored, so the tick still counts.
                    if (ring_q == CNT_ONE) begin
                        end_event = 1'b1;
                    end else if (ring_q != '0) begin
                        ring_d = ring_q - CNT_ONE;
                    end
                end
            end

            ST_SNOOZE: begin
                if (press_stop) begin
                    end_event = 1'b1;
                end else if (tick) begin
                    if (snz_q == CNT_ONE) begin
                        state_d = ST_RINGING;
                        ring_d  = RING_LOAD;
                    end else if (snz_q != '0) begin
                        snz_d = snz_q - CNT_ONE;
                    end
                end
            end

            default: begin
                state_d = ST_DISARMED;
            end
        endcase

        if (end_event) begin
            state_d = END_STATE;
            count_d = 2'd0;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= ST_DISARMED;
            ring_q  <= '0;
            snz_q   <= '0;
            count_q <= 2'd0;
        end else begin
            state_q <= state_d;
            ring_q  <= ring_d;
            snz_q   <= snz_d;
            count_q <= count_d;
        end
    end

    // Buzzer follows the next state so it is a clean flop output that is high
    // exactly during the RINGING cycles.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            buzzer_q <= 1'b0;
        end else begin
            buzzer_q <= (state_d == ST_RINGING);
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ahours_q   <= 8'd0;
            aminutes_q <= 8'd0;
            aseconds_q <= 8'd0;
            set_err_q  <= 1'b0;
        end else begin
            set_err_q <= set_reject;
            if (set_load) begin
                ahours_q   <= set_hours;
                aminutes_q <= set_minutes;
                aseconds_q <= set_seconds;
            end
        end
    end

    assign alarm_hours   = ahours_q;
    assign alarm_minutes = aminutes_q;
    assign alarm_seconds = aseconds_q;
    assign state         = state_q;
    assign buzzer        = buzzer_q;
    assign snooze_count  = count_q;
    assign set_err       = set_err_q;

endmodule

// File: tb/tb_alarm_sequencer.sv
// tb/tb_alarm_sequencer.sv - self-checking bench for alarm_sequencer with a behavioural reference model

module tb_alarm_sequencer;

    localparam int SNZ  = 3;
    localparam int RING = 5;
    localparam int MAXS = 3;

`ifdef ALARM_DAILY_REARM_EN
    localparam int END_ST = 1;
`else
    localparam int END_ST = 0;
`endif

    logic       clk = 1'b0;
    logic       reset_n;
    logic       tick;
    logic [7:0] cur_hours, cur_minutes, cur_seconds;
    logic       set_en;
    logic [7:0] set_hours, set_minutes, set_seconds;
    logic       btn_arm, btn_snooze, btn_stop;
    logic [7:0] alarm_hours, alarm_minutes, alarm_seconds;
    logic [1:0] state;
    logic       buzzer;
    logic [1:0] snooze_count;
    logic       set_err;

    int tests = 0;
    int fails = 0;

    // Reference model: mode 0..3 as user-visible lifecycle, times as seconds-of-day.
    int m_mode, m_alarm_sod, m_ring_left, m_snz_left, m_used, m_err, m_hold;

    alarm_sequencer #(
        .SNOOZE_SECS      (SNZ),
        .RING_TIMEOUT_SECS(RING),
        .MAX_SNOOZE       (MAXS)
    ) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .tick         (tick),
        .cur_hours    (cur_hours),
        .cur_minutes  (cur_minutes),
        .cur_seconds  (cur_seconds),
        .set_en       (set_en),
        .set_hours    (set_hours),
        .set_minutes  (set_minutes),
        .set_seconds  (set_seconds),
        .btn_arm      (btn_arm),
        .btn_snooze   (btn_snooze),
        .btn_stop     (btn_stop),
        .alarm_hours  (alarm_hours),
        .alarm_minutes(alarm_minutes),
        .alarm_seconds(alarm_seconds),
        .state        (state),
        .buzzer       (buzzer),
        .snooze_count (snooze_count),
        .set_err      (set_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_mode = 0; m_alarm_sod = 0; m_ring_left = 0; m_snz_left = 0;
        m_used = 0; m_err = 0; m_hold = 0;
    endtask

    task automatic model_update();
        int  cur_sod, new_mode;
        bit  same, finish, valid;
        cur_sod  = int'(cur_hours) * 3600 + int'(cur_minutes) * 60 + int'(cur_seconds);
        same     = (cur_sod == m_alarm_sod);
        valid    = (set_hours < 24) && (set_minutes < 60) && (set_seconds < 60);
        finish   = 1'b0;
        new_mode = m_mode;

        if (m_mode == 0) begin
            if (btn_arm && !btn_snooze && !btn_stop) new_mode = 1;
        end else if (m_mode == 1) begin
            if (btn_stop) new_mode = 0;
            else if (tick && same && m_hold == 0) begin
                new_mode = 2; m_ring_left = RING; m_used = 0;
            end
        end else if (m_mode == 2) begin
            if (btn_stop) finish = 1'b1;
            else if (btn_snooze && m_used < MAXS) begin
                new_mode = 3; m_snz_left = SNZ; m_used++;
            end else if (tick) begin
                m_ring_left--;
                if (m_ring_left == 0) finish = 1'b1;
            end
        end else begin
            if (btn_stop) finish = 1'b1;
            else if (tick) begin
                m_snz_left--;
                if (m_snz_left == 0) begin
                    new_mode = 2; m_ring_left = RING;
                end
            end
        end

        if (finish) begin
            new_mode = END_ST;
            m_used   = 0;
        end
`ifdef ALARM_DAILY_REARM_EN
        if (finish) m_hold = 1;
        else if (!same) m_hold = 0;
`endif
        m_err = (set_en && (m_mode == 2 || !valid)) ? 1 : 0;
        if (set_en && m_mode != 2 && valid)
            m_alarm_sod = int'(set_hours) * 3600 + int'(set_minutes) * 60 + int'(set_seconds);
        m_mode = new_mode;
    endtask

    task automatic compare_all();
        check("state", 32'(state), m_mode);
        check("buzzer", 32'(buzzer), (m_mode == 2) ? 1 : 0);
        check("alarm_hours", 32'(alarm_hours), m_alarm_sod / 3600);
        check("alarm_minutes", 32'(alarm_minutes), (m_alarm_sod / 60) % 60);
        check("alarm_seconds", 32'(alarm_seconds), m_alarm_sod % 60);
        check("snooze_count", 32'(snooze_count), m_used);
        check("set_err", 32'(set_err), m_err);
    endtask

    task automatic idle_inputs();
        tick = 0; set_en = 0; btn_arm = 0; btn_snooze = 0; btn_stop = 0;
    endtask

    task automatic step();
        model_update();
        @(posedge clk);
        #1;
        compare_all();
        idle_inputs();
    endtask

    task automatic set_cur(input int h, input int m, input int s);
        cur_hours = 8'(h); cur_minutes = 8'(m); cur_seconds = 8'(s);
    endtask

    task automatic set_req(input int h, input int m, input int s);
        set_en = 1; set_hours = 8'(h); set_minutes = 8'(m); set_seconds = 8'(s);
    endtask

    initial begin
        reset_n = 0;
        idle_inputs();
        set_cur(12, 0, 0);
        set_hours = 0; set_minutes = 0; set_seconds = 0;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        check("reset_state", 32'(state), 0);
        check("reset_buzzer", 32'(buzzer), 0);
        check("reset_alarm", {8'd0, alarm_hours, alarm_minutes, alarm_seconds}, 0);
        check("reset_snooze_count", 32'(snooze_count), 0);
        check("reset_set_err", 32'(set_err), 0);
        #2 reset_n = 1;
        step();

        set_req(7, 30, 0); step();
        check("set_hours_loaded", 32'(alarm_hours), 7);
        check("set_minutes_loaded", 32'(alarm_minutes), 30);
        set_req(24, 0, 0); step();
        check("bad_set_err", 32'(set_err), 1);
        check("bad_set_unchanged", 32'(alarm_hours), 7);
        step();
        check("set_err_one_cycle", 32'(set_err), 0);

        set_cur(7, 30, 0); tick = 1; step();
        check("disarmed_ignores_match", 32'(state), 0);
        btn_arm = 1; step();
        check("armed", 32'(state), 1);
        set_cur(7, 29, 59); tick = 1; step();
        check("no_early_ring", 32'(state), 1);
        set_cur(7, 30, 0); tick = 1; step();
        check("ring_state", 32'(state), 2);
        check("ring_buzzer", 32'(buzzer), 1);

        set_cur(7, 30, 1); set_req(6, 0, 0); step();
        check("set_in_ringing_err", 32'(set_err), 1);
        check("set_in_ringing_unchanged", 32'(alarm_hours), 7);

        for (int k = 1; k <= MAXS; k++) begin
            btn_snooze = 1; step();
            check("snooze_enter", 32'(state), 3);
            check("snooze_buzzer_off", 32'(buzzer), 0);
            check("snooze_count_inc", 32'(snooze_count), k);
            for (int t = 1; t <= SNZ; t++) begin
                tick = 1; step();
                check("snooze_expiry", 32'(state), (t == SNZ) ? 2 : 3);
            end
        end
        btn_snooze = 1; step();
        check("snooze_limit_stays_ringing", 32'(state), 2);
        check("snooze_limit_count", 32'(snooze_count), MAXS);

        for (int t = 1; t <= RING; t++) begin
            tick = 1; step();
            check("ring_timeout", 32'(state), (t == RING) ? END_ST : 2);
        end
        check("timeout_buzzer_off", 32'(buzzer), 0);
        check("timeout_count_clear", 32'(snooze_count), 0);

        btn_arm = 1; step();
        check("rearm", 32'(state), 1);
        set_cur(7, 30, 0); tick = 1; step();
        check("ring_again", 32'(state), 2);
        btn_stop = 1; btn_snooze = 1; tick = 1; step();
        check("stop_beats_snooze", 32'(state), END_ST);
        check("stop_count_clear", 32'(snooze_count), 0);
        tick = 1; step();
        check("no_retrigger_same_second", 32'(state), END_ST);

        set_cur(12, 0, 0); set_req(0, 0, 0); step();
        btn_arm = 1; step();
        set_cur(23, 59, 59); tick = 1; step();
        check("before_midnight", 32'(state), 1);
        set_cur(0, 0, 0); tick = 1; step();
        check("midnight_ring", 32'(state), 2);

        #2 reset_n = 0;
        #1;
        check("async_reset_buzzer", 32'(buzzer), 0);
        check("async_reset_state", 32'(state), 0);
        model_reset();
        @(posedge clk);
        #2 reset_n = 1;
        set_cur(0, 0, 0); tick = 1; step();
        check("disarmed_midnight_ignored", 32'(state), 0);

        for (int i = 0; i < 3000; i++) begin
            tick = ($urandom_range(0, 1) == 0);
            if ($urandom_range(0, 9) < 4)
                set_cur(m_alarm_sod / 3600, (m_alarm_sod / 60) % 60, m_alarm_sod % 60);
            else
                set_cur($urandom_range(0, 23), $urandom_range(0, 59), $urandom_range(0, 59));
            btn_stop   = ($urandom_range(0, 29) == 0);
            btn_snooze = ($urandom_range(0, 7) == 0);
            btn_arm    = ($urandom_range(0, 5) == 0);
            if ($urandom_range(0, 49) == 0)
                set_req($urandom_range(0, 25), $urandom_range(0, 62), $urandom_range(0, 62));
            step();
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/alarm_sequencer.md
Name: alarm_sequencer

Overview:
- Controller for the time-of-day alarm path.
- Holds the programmed alarm time; matches it against the running hours/minutes/seconds from the clock counter on each one-second tick.
- Sequences the user-visible alarm lifecycle: arm, ring, snooze, stop, timeout.
- Drives the buzzer enable and the stored alarm time back out to the display/compare logic.

Parameters:
SNOOZE_SECS, 300, ticks spent in SNOOZE before re-ringing (must be >= 1)
RING_TIMEOUT_SECS, 60, ticks in RINGING before automatic stop (must be >= 1)
MAX_SNOOZE, 3, maximum snoozes per alarm event

Ports:
clk  input  1  system clock
reset_n  input  1  asynchronous active-low reset
tick  input  1  one-cycle pulse, once per second, same cycle the clock counter advances
cur_hours  input  8  current hours, binary 0..23
cur_minutes  input  8  current minutes, binary 0..59
cur_seconds  input  8  current seconds, binary 0..59
set_en  input  1  one-cycle request to load a new alarm time
set_hours  input  8  alarm hours to load
set_minutes  input  8  alarm minutes to load
set_seconds  input  8  alarm seconds to load
btn_arm  input  1  one-cycle pulse, pre-debounced
btn_snooze  input  1  one-cycle pulse, pre-debounced
btn_stop  input  1  one-cycle pulse, pre-debounced
alarm_hours  output  8  stored alarm hours
alarm_minutes  output  8  stored alarm minutes
alarm_seconds  output  8  stored alarm seconds
state  output  2  0=DISARMED 1=ARMED 2=RINGING 3=SNOOZE
buzzer  output  1  registered; high exactly while state==RINGING
snooze_count  output  2  snoozes used in current event (saturates at MAX_SNOOZE)
set_err  output  1  one-cycle pulse: set request rejected

Behaviour:
- Clock and reset: clk; reset_n async assert, sync deassert.
- Reset values: state=DISARMED, alarm time=00:00:00, buzzer=0, snooze_count=0, set_err=0, internal ring/snooze counters=0.
- Reset mid-RINGING or mid-SNOOZE drops buzzer immediately (async).
- Set load, accepted in any state except RINGING:
  - Valid iff set_hours<=23, set_minutes<=59, set_seconds<=59.
  - Valid: registers update next edge; state unchanged.
  - Invalid, or set_en while RINGING: registers unchanged, set_err=1 for one cycle.
- Button priority in the same cycle: btn_stop > btn_snooze > btn_arm.
- DISARMED:
  - btn_arm -> ARMED.
  - Matches are ignored.
- ARMED:
  - btn_stop -> DISARMED.
  - tick && cur time == alarm time (all three fields) -> RINGING.
  - On that transition: ring_cnt=RING_TIMEOUT_SECS, snooze_count=0.
  - Latency: buzzer rises on the edge after the matching tick cycle.
- RINGING (buzzer=1):
  - btn_stop -> end of event.
  - btn_snooze && snooze_count<MAX_SNOOZE -> SNOOZE; snooze_cnt=SNOOZE_SECS; snooze_count+1.
  - btn_snooze at limit is ignored (stays RINGING).
  - Otherwise, on each tick ring_cnt decrements. A tick with ring_cnt==1 -> end of event (timeout).
- SNOOZE (buzzer=0):
  - btn_stop -> end of event.
  - On each tick snooze_cnt decrements. A tick with snooze_cnt==1 -> RINGING, ring_cnt reloaded.
  - Time matches are ignored.
- End of event: next state set by the optional feature; snooze_count cleared.
- Button and tick in the same cycle: the button wins; the counter does not decrement that cycle.
- Wrap-around: matching is pure equality, so 23:59:59 -> 00:00:00 needs no special case. An alarm at 00:00:00 fires at midnight.
- Counter width: $clog2(max(SNOOZE_SECS,RING_TIMEOUT_SECS)+1) bits, unsigned. Counters never underflow.

Optional Feature:
- Macro: ALARM_DAILY_REARM_EN.
- Defined: end of event goes to ARMED, so the alarm fires again at the same time next day.
  - Re-match is suppressed until cur time differs from alarm time, so a stop within the match second cannot retrigger.
- Undefined: end of event goes to DISARMED; btn_arm is required to re-arm.

Test Plan:
- Reset with buttons idle -> state=0, buzzer=0, alarm=00:00:00. Pulse reset_n low during RINGING -> buzzer=0 immediately.
- set 07:30:00, btn_arm, drive time 07:29:59 then tick with 07:30:00 -> state=2, buzzer=1 one clk later. set 24:00:00 -> set_err pulse, alarm regs unchanged.
- RINGING, btn_snooze with SNOOZE_SECS=3 -> state=3, buzzer=0. After 3 ticks -> state=2, snooze_count=1. Fourth snooze attempt with MAX_SNOOZE=3 -> stays RINGING.
- RINGING, RING_TIMEOUT_SECS=5, no buttons, 5 ticks -> state=0 (macro off) or state=1 (macro on); buzzer=0.
- Same cycle btn_stop+btn_snooze+tick in RINGING -> end of event, no SNOOZE entry.
- Alarm 00:00:00 armed, time advances 23:59:59 -> 00:00:00 with tick -> RINGING. DISARMED with a matching tick -> stays DISARMED.
